// File: rtl/chord_song_reader.sv
// Song ROM sequencer: walks up to 32 words of the selected song and issues note/advance load strobes.
// state     | meaning
// IDLE      | waiting for play
// FETCH     | rom_addr presented for the current idx
// WAIT_ROM  | ROM read latency; word captured on exit
// DECODE    | end marker / advance / note dispatch
// LOAD_NOTE | waits for a free voice, then strobes (skipped for duration 0)
// LOAD_ADV  | unconditional advance strobe
// WAIT_ADV  | waits for the downstream advance timer to reach zero
// DONE      | song finished; a new song selection restarts
module chord_song_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic [1:0]  song,
    input  logic        note_done,
    input  logic        activate_done,
    output logic [6:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [5:0]  note_to_load,
    output logic [5:0]  duration,
    output logic        load_new_note,
    output logic        activate,
    output logic        song_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_ROM,
        S_DECODE,
        S_LOAD_NOTE,
        S_LOAD_ADV,
        S_WAIT_ADV,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [4:0]  r_idx;
    logic [1:0]  r_song;
    logic [15:0] r_word;

    logic w_song_change;
    logic w_dur_zero;
    logic w_last;
    logic w_strobe_note;
    logic w_strobe_adv;

    assign w_song_change = play && (song != r_song) && (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_dur_zero    = (r_word[8:3] == 6'd0);
    assign w_last        = (r_idx == 5'd31);

    // Strobes decode straight from the state register so an async reset removes them at once.
    assign w_strobe_note = play && !w_song_change && (r_state == S_LOAD_NOTE) && !w_dur_zero && note_done;
    assign w_strobe_adv  = play && !w_song_change && (r_state == S_LOAD_ADV);

    assign rom_addr      = {r_song, r_idx};
    assign note_to_load  = r_word[14:9];
    assign duration      = r_word[8:3];
    assign load_new_note = w_strobe_note || w_strobe_adv;
    assign activate      = w_strobe_adv;
    assign song_done     = (r_state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= 5'd0;
            r_song  <= 2'd0;
            r_word  <= 16'h0000;
        end else if (play) begin
            if (w_song_change) begin
                r_song  <= song;
                r_idx   <= 5'd0;
                r_state <= S_FETCH;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_song  <= song;
                        r_idx   <= 5'd0;
                        r_state <= S_FETCH;
                    end
                    S_FETCH: r_state <= S_WAIT_ROM;
                    S_WAIT_ROM: begin
                        r_word  <= rom_data;
                        r_state <= S_DECODE;
                    end
                    S_DECODE: begin
                        if (r_word == 16'h0000)
                            r_state <= S_DONE;
                        else if (r_word[15])
                            r_state <= S_LOAD_ADV;
                        else
                            r_state <= S_LOAD_NOTE;
                    end
                    S_LOAD_NOTE: begin
                        if (w_dur_zero || note_done) begin
                            r_state <= w_last ? S_DONE : S_FETCH;
                            if (!w_last)
                                r_idx <= r_idx + 5'd1;
                        end
                    end
                    S_LOAD_ADV: r_state <= S_WAIT_ADV;
                    S_WAIT_ADV: begin
                        if (activate_done) begin
                            r_state <= w_last ? S_DONE : S_FETCH;
                            if (!w_last)
                                r_idx <= r_idx + 5'd1;
                        end
                    end
                    S_DONE: begin
                        if (song != r_song) begin
                            r_song  <= song;
                            r_idx   <= 5'd0;
                            r_state <= S_FETCH;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chord_song_reader.sv
// Bench for chord_song_reader: directed scenarios plus randomized songs checked against a word-list model.
module tb_chord_song_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        play = 1'b0;
    logic [1:0]  song = 2'd0;
    logic        note_done = 1'b0;
    logic        activate_done = 1'b0;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data;
    logic [5:0]  note_to_load;
    logic [5:0]  duration;
    logic        load_new_note;
    logic        activate;
    logic        song_done;

    logic [15:0] rom [0:127];
    logic [12:0] obs_q [$];
    logic [12:0] exp_q [$];
    logic        prev_strobe = 1'b0;
    int          checks = 0;
    int          errors = 0;

    chord_song_reader dut (
        .clk           (clk),
        .reset         (reset),
        .play          (play),
        .song          (song),
        .note_done     (note_done),
        .activate_done (activate_done),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .note_to_load  (note_to_load),
        .duration      (duration),
        .load_new_note (load_new_note),
        .activate      (activate),
        .song_done     (song_done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for an address appears one cycle later.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Strobe monitor: records every load and checks the strobe protocol.
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if (activate && !load_new_note) begin
                errors++;
                $display("FAIL mon_activate_alone activate=%0b load_new_note=%0b", activate, load_new_note);
            end
            if (load_new_note) begin
                checks++;
                if (prev_strobe) begin
                    errors++;
                    $display("FAIL mon_double_strobe got two consecutive strobes want one");
                end
                checks++;
                if (!play) begin
                    errors++;
                    $display("FAIL mon_strobe_paused got strobe with play=0 want none");
                end
                obs_q.push_back({activate, note_to_load, duration});
            end
        end
        prev_strobe = load_new_note;
    end

    initial begin
        #600000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        play = 1'b0;
        note_done = 1'b0;
        activate_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        obs_q.delete();
    endtask

    task automatic wait_strobe(input int max_cyc, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (load_new_note) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int max_cyc, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (song_done) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Expected strobes of one song: words in order until the end marker;
    // advance words always load, note words load unless their duration is 0.
    function automatic void build_expected(input logic [1:0] s);
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            logic [15:0] w;
            w = rom[{s, 5'(i)}];
            if (w == 16'h0000) break;
            if (w[15])
                exp_q.push_back({1'b1, w[14:9], w[8:3]});
            else if (w[8:3] != 6'd0)
                exp_q.push_back({1'b0, w[14:9], w[8:3]});
        end
    endfunction

    task automatic test_reset();
        clear_rom();
        rom[32] = 16'h0C50;
        reset = 1'b0;
        play = 1'b1;
        song = 2'd1;
        note_done = 1'b1;
        activate_done = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (rom_addr !== 7'd0) begin errors++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
        checks++; if (note_to_load !== 6'd0) begin errors++; $display("FAIL reset_note got %0d want 0", note_to_load); end
        checks++; if (duration !== 6'd0) begin errors++; $display("FAIL reset_duration got %0d want 0", duration); end
        checks++; if (load_new_note !== 1'b0) begin errors++; $display("FAIL reset_load got %0b want 0", load_new_note); end
        checks++; if (activate !== 1'b0) begin errors++; $display("FAIL reset_activate got %0b want 0", activate); end
        checks++; if (song_done !== 1'b0) begin errors++; $display("FAIL reset_song_done got %0b want 0", song_done); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (rom_addr !== 7'd0) begin errors++; $display("FAIL release_still_idle got %0d want 0", rom_addr); end
        tick();
        @(negedge clk);
        checks++; if (rom_addr !== 7'd32) begin errors++; $display("FAIL release_first_fetch got %0d want 32", rom_addr); end
        do_reset();
    endtask

    task automatic test_note_basic();
        bit f;
        clear_rom();
        rom[32] = 16'h0C50;
        do_reset();
        song = 2'd1;
        note_done = 1'b1;
        play = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (rom_addr !== 7'd32) begin errors++; $display("FAIL basic_fetch_addr got %0d want 32", rom_addr); end
        wait_strobe(10, f);
        checks++; if (!f) begin errors++; $display("FAIL basic_strobe got none want strobe"); end
        checks++; if (note_to_load !== 6'd6) begin errors++; $display("FAIL basic_note got %0d want 6", note_to_load); end
        checks++; if (duration !== 6'd10) begin errors++; $display("FAIL basic_duration got %0d want 10", duration); end
        checks++; if (activate !== 1'b0) begin errors++; $display("FAIL basic_activate got %0b want 0", activate); end
        tick();
        @(negedge clk);
        checks++; if (load_new_note !== 1'b0) begin errors++; $display("FAIL basic_single_cycle got %0b want 0", load_new_note); end
        wait_done(20, f);
        checks++; if (!f) begin errors++; $display("FAIL basic_done got 0 want 1"); end
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL basic_strobe_count got %0d want 1", obs_q.size()); end
    endtask

    task automatic test_advance_pause();
        bit f;
        int bad;
        clear_rom();
        rom[64] = 16'h8060;
        rom[65] = 16'h0C50;
        do_reset();
        song = 2'd2;
        note_done = 1'b1;
        activate_done = 1'b0;
        play = 1'b1;
        wait_strobe(10, f);
        checks++; if (!f) begin errors++; $display("FAIL adv_strobe got none want strobe"); end
        checks++; if (activate !== 1'b1) begin errors++; $display("FAIL adv_activate got %0b want 1", activate); end
        checks++; if (duration !== 6'd12 || note_to_load !== 6'd0) begin errors++; $display("FAIL adv_fields got note %0d dur %0d want note 0 dur 12", note_to_load, duration); end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            @(negedge clk);
            if (rom_addr !== 7'd64 || load_new_note) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL adv_wait_hold got %0d bad cycles want 0", bad); end
        tick();
        play = 1'b0;
        activate_done = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rom_addr !== 7'd64 || load_new_note || activate || song_done) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL pause_hold got %0d bad cycles want 0", bad); end
        play = 1'b1;
        @(negedge clk);
        checks++; if (rom_addr !== 7'd64) begin errors++; $display("FAIL resume_wait_adv got %0d want 64", rom_addr); end
        tick();
        @(negedge clk);
        checks++; if (rom_addr !== 7'd65) begin errors++; $display("FAIL resume_next_fetch got %0d want 65", rom_addr); end
        wait_strobe(10, f);
        checks++; if (!f || note_to_load !== 6'd6 || activate !== 1'b0) begin errors++; $display("FAIL resume_note got found %0b note %0d act %0b want 1 6 0", f, note_to_load, activate); end
    endtask

    task automatic test_wait_note();
        int bad;
        clear_rom();
        rom[96] = 16'h5438;
        do_reset();
        song = 2'd3;
        note_done = 1'b0;
        play = 1'b1;
        repeat (4) tick();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (load_new_note || note_to_load !== 6'd42 || duration !== 6'd7) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wait_note_hold got %0d bad cycles want 0", bad); end
        note_done = 1'b1;
        @(negedge clk);
        checks++; if (load_new_note !== 1'b1) begin errors++; $display("FAIL wait_note_fire got %0b want 1", load_new_note); end
        checks++; if (note_to_load !== 6'd42) begin errors++; $display("FAIL wait_note_value got %0d want 42", note_to_load); end
        tick();
        @(negedge clk);
        checks++; if (load_new_note !== 1'b0) begin errors++; $display("FAIL wait_note_drop got %0b want 0", load_new_note); end
    endtask

    task automatic test_song_change();
        bit f;
        clear_rom();
        rom[32] = 16'h0C50;
        rom[64] = 16'h0A48;
        do_reset();
        song = 2'd1;
        note_done = 1'b0;
        play = 1'b1;
        repeat (4) tick();
        song = 2'd2;
        note_done = 1'b1;
        @(negedge clk);
        checks++; if (load_new_note !== 1'b0) begin errors++; $display("FAIL change_priority got %0b want 0", load_new_note); end
        tick();
        @(negedge clk);
        checks++; if (rom_addr !== 7'd64) begin errors++; $display("FAIL change_fetch got %0d want 64", rom_addr); end
        wait_strobe(10, f);
        checks++; if (!f || note_to_load !== 6'd5 || duration !== 6'd9) begin errors++; $display("FAIL change_new_word got found %0b note %0d dur %0d want 1 5 9", f, note_to_load, duration); end
        wait_done(20, f);
        checks++; if (!f || obs_q.size() != 1) begin errors++; $display("FAIL change_count got done %0b strobes %0d want 1 1", f, obs_q.size()); end
    endtask

    task automatic test_end_marker();
        bit f;
        int bad;
        clear_rom();
        for (int i = 0; i < 5; i++)
            rom[32 + i] = {1'b0, 6'($urandom), 6'($urandom_range(1, 63)), 3'($urandom)};
        rom[64] = 16'h0C50;
        build_expected(2'd1);
        do_reset();
        song = 2'd1;
        note_done = 1'b1;
        activate_done = 1'b1;
        play = 1'b1;
        wait_done(200, f);
        checks++; if (!f) begin errors++; $display("FAIL end_done got 0 want 1"); end
        checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL end_count got %0d want 5", obs_q.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL end_entry %0d got %h want %h", k, obs_q[k], exp_q[k]); end
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            if (load_new_note || !song_done) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL end_stays_done got %0d bad cycles want 0", bad); end
        tick();
        song = 2'd2;
        @(negedge clk);
        checks++; if (song_done !== 1'b1) begin errors++; $display("FAIL end_done_until_edge got %0b want 1", song_done); end
        tick();
        @(negedge clk);
        checks++; if (rom_addr !== 7'd64 || song_done !== 1'b0) begin errors++; $display("FAIL end_new_song got addr %0d done %0b want 64 0", rom_addr, song_done); end
    endtask

    task automatic test_reset_mid_adv();
        bit f;
        clear_rom();
        rom[32] = 16'h8C50;
        do_reset();
        song = 2'd1;
        note_done = 1'b1;
        activate_done = 1'b0;
        play = 1'b1;
        wait_strobe(10, f);
        checks++; if (!f || activate !== 1'b1) begin errors++; $display("FAIL midrst_strobe got found %0b act %0b want 1 1", f, activate); end
        reset = 1'b0;
        #1;
        checks++; if (load_new_note !== 1'b0 || activate !== 1'b0) begin errors++; $display("FAIL midrst_drop got load %0b act %0b want 0 0", load_new_note, activate); end
        checks++; if (rom_addr !== 7'd0 || note_to_load !== 6'd0 || duration !== 6'd0 || song_done !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got addr %0d note %0d dur %0d done %0b want 0 0 0 0", rom_addr, note_to_load, duration, song_done);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (rom_addr !== 7'd0) begin errors++; $display("FAIL midrst_idle got %0d want 0", rom_addr); end
        tick();
        @(negedge clk);
        checks++; if (rom_addr !== 7'd32) begin errors++; $display("FAIL midrst_restart got %0d want 32", rom_addr); end
        wait_strobe(10, f);
        checks++; if (!f || activate !== 1'b1 || note_to_load !== 6'd6 || duration !== 6'd10) begin
            errors++; $display("FAIL midrst_again got found %0b act %0b note %0d dur %0d want 1 1 6 10", f, activate, note_to_load, duration);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            logic [1:0]  s;
            logic [15:0] w;
            bit          done;
            s = 2'($urandom_range(0, 3));
            clear_rom();
            for (int i = 0; i < 32; i++) begin
                w = 16'($urandom);
                if ($urandom_range(0, 5) == 0) w[8:3] = 6'd0;
                if (w == 16'h0000) w = 16'h0001;
                if (t != 0 && $urandom_range(0, 39) == 0) w = 16'h0000;
                rom[{s, 5'(i)}] = w;
            end
            build_expected(s);
            do_reset();
            song = s;
            play = 1'b1;
            done = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (song_done) begin
                    done = 1'b1;
                    break;
                end
                tick();
                play = ($urandom_range(0, 7) != 0);
                note_done = ($urandom_range(0, 3) != 0);
                activate_done = ($urandom_range(0, 2) == 0);
            end
            checks++; if (!done) begin errors++; $display("FAIL rand_done trial %0d got 0 want 1", t); end
            if (t == 0) begin
                checks++;
                if (rom_addr !== {s, 5'd31}) begin errors++; $display("FAIL rand_last_idx got %0d want %0d", rom_addr, {s, 5'd31}); end
            end
            checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count trial %0d got %0d want %0d", t, obs_q.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_entry trial %0d idx %0d got %h want %h", t, k, obs_q[k], exp_q[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_note_basic();
        test_advance_pause();
        test_wait_note();
        test_song_change();
        test_end_marker();
        test_reset_mid_adv();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chord_song_reader.md
CHORD_SONG_READER -- requirements
Module: chord_song_reader

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; low forces the reset state immediately, independent of clk.
REQ-003 SHALL have port play, input, 1 bit: high runs the sequencer; low freezes it.
REQ-004 SHALL have port song, input, 2 bits: selects one of 4 songs of 32 words each.
REQ-005 SHALL have port note_done, input, 1 bit: high when at least one chord voice is free.
REQ-006 SHALL have port activate_done, input, 1 bit: high when the downstream advance timer is zero.
REQ-007 SHALL have port rom_addr, output, 7 bits: ROM word address, equal to {song, idx[4:0]}.
REQ-008 SHALL have port rom_data, input, 16 bits: ROM word, valid exactly 1 cycle after rom_addr is driven.
REQ-009 SHALL have port note_to_load, output, 6 bits: note field of the current word.
REQ-010 SHALL have port duration, output, 6 bits: duration field of the current word, in beats.
REQ-011 SHALL have port load_new_note, output, 1 bit: single-cycle load strobe.
REQ-012 SHALL have port activate, output, 1 bit: high together with load_new_note when the word is an advance word.
REQ-013 SHALL have port song_done, output, 1 bit: level, high while in DONE.

Function
REQ-014 SHALL decode each ROM word as: [15] advance flag, [14:9] note, [8:3] duration, [2:0] ignored.
REQ-015 SHALL implement the states IDLE, FETCH, WAIT_ROM, DECODE, LOAD_NOTE, LOAD_ADV, WAIT_ADV and DONE.
REQ-016 SHALL move IDLE->FETCH when play=1; on this move it latches song and sets idx=0.
REQ-017 SHALL drive rom_addr in FETCH, then move FETCH->WAIT_ROM->DECODE, registering rom_data into a word register on the WAIT_ROM->DECODE edge.
REQ-018 SHALL, in DECODE, move to DONE if the word is 16'h0000 (end marker).
REQ-019 SHALL, in DECODE, move to LOAD_ADV if advance=1, and otherwise move to LOAD_NOTE.
REQ-020 SHALL, in LOAD_NOTE with duration!=0, wait until note_done=1, then assert load_new_note=1 and activate=0 for exactly that one cycle, then go to NEXT.
REQ-021 SHALL, in LOAD_NOTE with duration=0, skip the word: no strobe, go to NEXT.
REQ-022 SHALL, in LOAD_ADV, assert load_new_note=1 and activate=1 for one cycle unconditionally, then move to WAIT_ADV.
REQ-023 SHALL move WAIT_ADV->NEXT on the first cycle with activate_done=1 (a duration-0 advance therefore completes the cycle after the strobe).
REQ-024 SHALL implement NEXT (a transition, not a state) as: if idx=31 go to DONE, else idx+1 and go to FETCH; idx SHALL never wrap silently.
REQ-025 SHALL hold note_to_load and duration stable from DECODE until the state is next left through NEXT.
REQ-026 SHALL make load_new_note never high for 2 consecutive cycles, and never high in any state other than LOAD_NOTE and LOAD_ADV.
REQ-027 SHALL keep song_done=1 in DONE, and leave DONE for FETCH (idx=0, new song latched) when song differs from the latched song.
REQ-028 SHALL, when play=0, hold state, idx and the word register, and force load_new_note=0 and activate=0; on resume it continues where it stopped.
REQ-029 SHALL, when song changes while not in IDLE or DONE and play=1, abort the current word, set idx=0, latch the new song and go to FETCH the next cycle; no strobe is issued in that cycle.
REQ-030 SHALL give song change priority over the LOAD_NOTE and LOAD_ADV strobe when both occur in the same cycle.

Reset
REQ-031 SHALL, with reset=0, force state=IDLE, idx=0, latched song=0 and word=0.
REQ-032 SHALL, with reset=0, drive rom_addr=0, note_to_load=0, duration=0, load_new_note=0, activate=0 and song_done=0.
REQ-033 SHALL, when reset is asserted mid-strobe, drop load_new_note in the same cycle (asynchronously).
REQ-034 SHALL leave IDLE no earlier than the first rising edge after reset is released.

Verification
REQ-035 SHALL pass this scenario: song=1, word0=16'h0C50 (note 6, dur 10), note_done=1 -> a single strobe with note_to_load=6, duration=10, activate=0, and rom_addr=7'd32 during FETCH.
REQ-036 SHALL pass this scenario: word=16'h8060 (advance, dur 12), activate_done driven low for 12 cycles after the strobe -> strobe with activate=1, no FETCH of the next word until activate_done=1.
REQ-037 SHALL pass this scenario: note word with note_done=0 for 20 cycles -> load_new_note stays 0 and outputs stay stable; the strobe fires the cycle note_done rises.
REQ-038 SHALL pass this scenario: word=16'h0000 at idx 5 -> DONE, song_done=1, no further strobes; changing song 1->2 -> rom_addr=7'd64.
REQ-039 SHALL pass this scenario: play=0 during WAIT_ADV for 50 cycles -> no transitions; after play=1 it resumes WAIT_ADV; 32 non-zero words -> song_done after idx 31.
REQ-040 SHALL pass this scenario: reset pulsed low mid-LOAD_ADV -> all outputs 0 immediately; after release it starts at idx 0.
